// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and defaults for the skid pipeline stage
// No ports; imported by pipe_data_reg and pipe_skid_reg.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] pipe_state_t;

  // Occupancy-encoded states; 2'd3 is unused and recovers to EMPTY.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - WIDTH-bit data register with load enable and sync reset
// Ports: clk, rst (sync, active-high, clears to 0), en (load), d (next value), q (held value).
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline register with one-entry skid buffer
// Ports: clk, rst (sync, active-high), flush (squash held entries),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream),
//        xfer_count (wrapping count of output transfers).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);

  pipe_state_t      state_d;
  pipe_state_t      state_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_in;
  logic [WIDTH-1:0] main_out;
  logic [WIDTH-1:0] skid_out;

  // Handshake outputs decode straight from the state flop, so no input
  // reaches in_ready/out_valid combinationally.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_out;
  assign xfer_count = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    cnt_d          = cnt_q;

    // The downstream consumed a beat even if it is being flushed.
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      // Entries are abandoned in place; their contents no longer matter.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid holds the older entry, so it moves up before any new input.
          if (out_fire) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_in = main_from_skid ? skid_out : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_in),
    .q   (main_out)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_out)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Pipeline stage register with a valid/ready handshake and a one-entry skid buffer, placed between adjacent pipeline stages (e.g. IF->ID) of the core.
- Gives full throughput (1 transfer/cycle) with a registered in_ready, so downstream stalls never form a combinational ready path back upstream.
- Supports a synchronous flush for branch/exception squash, plus a wrapping transfer counter for debug.

Parameters:
- WIDTH, 32, payload width in bits (>=1)
- CNT_W, 16, width of the xfer_count debug counter (>=1)

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept; registered
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload to downstream; registered
- xfer_count  output  CNT_W  number of completed output transfers, wraps

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are evaluated on the same edge.
- State machine (2-bit):
  - EMPTY: neither main nor skid holds data.
  - ONE: only main holds data.
  - TWO: main and skid both hold data.
- Outputs from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - out_data = main register.
  - All of these are register outputs with no combinational input->output path.
- Transitions (when rst=0 and flush=0):
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data.
  - ONE: in_fire only -> TWO, skid <= in_data.
  - ONE: out_fire only -> EMPTY.
  - ONE: neither -> hold.
  - TWO: in_ready=0, so no in_fire. out_fire -> ONE, main <= skid. Otherwise hold.
- Ordering: the skid entry is always older than any new input. Output order equals input order, with no duplication and no loss.
- Data hold: main and skid change only under the conditions above. While out_valid=1 and out_ready=0, out_data is stable.
- Reset (rst=1, highest priority):
  - state=EMPTY, main=0, skid=0, xfer_count=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_data=0.
  - Reset mid-transfer discards everything. in_fire/out_fire in that cycle have no effect.
- Flush (flush=1, rst=0):
  - state <= EMPTY; main/skid contents are left unchanged (don't-care).
  - An out_fire in the flush cycle still counts: the downstream saw a valid beat, so xfer_count increments.
  - An in_fire in the flush cycle is dropped; the entry is not captured.
  - Next cycle: out_valid=0, in_ready=1.
- xfer_count: +1 on every out_fire (including in a flush cycle), modulo 2^CNT_W; all-ones wraps to 0. Cleared only by rst.
- Latency and throughput:
  - in_fire at edge N gives out_valid=1 with that data after edge N (visible in cycle N+1).
  - Sustained out_ready=1 gives 1 beat/cycle.
  - Max occupancy is 2.
- Illegal state encoding (the 4th code) recovers to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - state typedef/localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Default WIDTH constant.
- One natural sub-module, pipe_data_reg:
  - WIDTH-bit register with enable and sync active-high reset to 0.
  - Instantiated twice (main, skid). The control FSM and counter stay in pipe_skid_reg.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, in_ready=1, out_data=0, xfer_count=0; nothing is captured.
- Streaming: out_ready=1, feed 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data 0x1..0x4 on consecutive cycles one cycle later; in_ready stays 1; xfer_count=4.
- Backpressure/skid: out_ready=0, offer 0xA then 0xB then 0xC -> 0xA, 0xB accepted and in_ready=0 while 0xC is held. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order, with no loss or duplication.
- Flush with both entries full, in_valid=1 (0x55) in the same cycle -> next cycle out_valid=0, in_ready=1; 0x55 is never output.
- Simultaneous in_fire/out_fire in ONE (main=0x10, in=0x20) -> stays ONE, out_data=0x20, xfer_count +1.
- Counter wrap with CNT_W=2: five transfers -> xfer_count sequence 1,2,3,0,1.
